// File: rtl/uart_rx_deserializer_if.sv
// Bundles the UART RX line, frame configuration and received-byte outputs.
// The deserializer uses the slave side; the line driver / consumer uses master.
interface uart_rx_deserializer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic                      RX_IN;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] Prescale;
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      data_valid;
  logic                      par_err;
  logic                      stp_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: oversampled start detection, 3-point majority
// vote per bit, LSB-first data, optional parity, stop check, one-cycle pulses.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input logic                   clk,
  input logic                   rst,
  uart_rx_deserializer_if.slave rx_if
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state_q,    state_d;
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]            bit_cnt_q,  bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q,    shift_d;
  logic [2:0]                samp_q,     samp_d;
  logic                      par_en_q,   par_en_d;
  logic                      par_typ_q,  par_typ_d;
  logic                      perr_q,     perr_d;
  logic [DATA_WIDTH-1:0]     p_data_q,   p_data_d;
  logic                      dv_q,       dv_d;
  logic                      pe_q,       pe_d;
  logic                      se_q,       se_d;

  logic [PRESCALE_WIDTH-1:0] presc_m1;
  logic [PRESCALE_WIDTH-1:0] half;
  logic [PRESCALE_WIDTH-1:0] half_m1;
  logic [PRESCALE_WIDTH-1:0] half_p1;
  logic                      end_of_bit;
  logic                      bit_val;

  function automatic logic maj3(input logic [2:0] s);
    maj3 = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  assign presc_m1   = rx_if.Prescale - PRESCALE_WIDTH'(1);
  assign half       = rx_if.Prescale >> 1;
  assign half_m1    = half - PRESCALE_WIDTH'(1);
  assign half_p1    = half + PRESCALE_WIDTH'(1);
  assign end_of_bit = (edge_cnt_q == presc_m1);
  // All three samples are settled long before the end-of-bit decision edge.
  assign bit_val    = maj3(samp_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      perr_q     <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      perr_q     <= perr_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    perr_d     = perr_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;

    if (state_q != IDLE) begin
      edge_cnt_d = end_of_bit ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
      if (edge_cnt_q == half_m1) samp_d[0] = rx_if.RX_IN;
      if (edge_cnt_q == half)    samp_d[1] = rx_if.RX_IN;
      if (edge_cnt_q == half_p1) samp_d[2] = rx_if.RX_IN;
    end

    case (state_q)
      IDLE: begin
        // The detection cycle itself is edge 0 of the start bit.
        if (!rx_if.RX_IN) begin
          state_d    = START;
          edge_cnt_d = PRESCALE_WIDTH'(1);
          bit_cnt_d  = '0;
          par_en_d   = rx_if.PAR_EN;
          par_typ_d  = rx_if.PAR_TYP;
          perr_d     = 1'b0;
        end
      end
      START: begin
        if (end_of_bit) state_d = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (end_of_bit) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (end_of_bit) begin
          if (bit_val != ((^shift_q) ^ par_typ_q)) perr_d = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        if (end_of_bit) begin
          se_d = ~bit_val;
          pe_d = perr_q;
          if (bit_val && !perr_q) begin
            p_data_d = shift_q;
            dv_d     = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rx_if.P_DATA     = p_data_q;
  assign rx_if.data_valid = dv_q;
  assign rx_if.par_err    = pe_q;
  assign rx_if.stp_err    = se_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: frames built from bit lists, outcome predicted from
// frame content, directed scenarios followed by randomized frames.
module tb_uart_rx_deserializer;
  localparam int DW = 8;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_deserializer_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

  uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx_if (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [DW-1:0] exp_pdata;
  logic          o_dv, o_pe, o_se;
  logic [DW-1:0] o_pd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one line cycle; afterwards o_* hold what is visible in the next cycle.
  task automatic step(input logic v);
    bus.RX_IN = v;
    @(posedge clk);
    #1;
    o_dv = bus.data_valid;
    o_pe = bus.par_err;
    o_se = bus.stp_err;
    o_pd = bus.P_DATA;
  endtask

  task automatic idle(input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      if (o_dv || o_pe || o_se) bad++;
    end
    chk({tag, " idle_quiet"}, bad, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, " P_DATA"},     bus.P_DATA,     0);
    chk({tag, " data_valid"}, bus.data_valid, 0);
    chk({tag, " par_err"},    bus.par_err,    0);
    chk({tag, " stp_err"},    bus.stp_err,    0);
  endtask

  // gbit/goff place a one-cycle inverted glitch (gbit<0: none);
  // abort_c asserts reset at that frame cycle (abort_c<0: never).
  task automatic send_frame(input string tag, input logic [DW-1:0] data, input int presc,
                            input logic pen, input logic ptyp, input logic bad_par,
                            input logic stop_bit, input int gbit, input int goff,
                            input int abort_c);
    logic line[$];
    int   nbits, total, bad;
    logic v, ese, epe, edv;
    line = {};
    line.push_back(1'b0);
    for (int i = 0; i < DW; i++) line.push_back(data[i]);
    if (pen) line.push_back((^data) ^ ptyp ^ bad_par);
    line.push_back(stop_bit);
    nbits = line.size();
    total = nbits * presc;
    bus.Prescale = PW'(presc);
    bus.PAR_EN   = pen;
    bus.PAR_TYP  = ptyp;
    bad = 0;
    for (int c = 0; c < total; c++) begin
      if (c == abort_c) begin
        rst = 1'b0;
        #1;
        check_outputs_zero({tag, " abort"});
        exp_pdata = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        return;
      end
      v = line[c / presc];
      if ((c / presc) == gbit && (c % presc) == goff) v = ~v;
      step(v);
      if (c == 0) begin
        bus.PAR_EN  = 1'($urandom);
        bus.PAR_TYP = 1'($urandom);
      end
      if (c < total - 1 && (o_dv || o_pe || o_se)) bad++;
    end
    ese = ~stop_bit;
    epe = pen & bad_par;
    edv = !ese && !epe;
    if (edv) exp_pdata = data;
    chk({tag, " quiet"},      bad,  0);
    chk({tag, " data_valid"}, o_dv, edv);
    chk({tag, " par_err"},    o_pe, epe);
    chk({tag, " stp_err"},    o_se, ese);
    chk({tag, " P_DATA"},     o_pd, exp_pdata);
  endtask

  initial begin
    int bad, p, gb, go, gap;
    logic [DW-1:0] d;
    logic pen, ptyp, bp, sb;

    rst          = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.Prescale = PW'(8);
    exp_pdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b1;
    idle(4, "post_reset");

    send_frame("8N1_A5", 8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    idle(3, "g1");

    send_frame("8E1_3C_ok",  8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    idle(3, "g2");
    send_frame("8E1_3C_bad", 8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0, -1);
    idle(3, "g3");

    send_frame("8N1_81_stp0", 8'h81, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, -1);
    idle(3, "g4");
    send_frame("8O1_both",    8'h81, 32, 1'b1, 1'b1, 1'b1, 1'b0, -1, 0, -1);
    idle(3, "g5");

    // Short low pulse must be rejected as a false start after one bit time.
    bus.Prescale = PW'(16);
    bad = 0;
    for (int c = 0; c < 16; c++) begin
      step(c < 3 ? 1'b0 : 1'b1);
      if (o_dv || o_pe || o_se) bad++;
    end
    chk("false_start quiet", bad, 0);
    send_frame("after_glitch_55", 8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    idle(2, "g6");
    send_frame("data_glitch", 8'h6B, 16, 1'b0, 1'b0, 1'b0, 1'b1, 4, 8, -1);
    idle(2, "g7");

    send_frame("b2b_12", 8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    send_frame("b2b_EF", 8'hEF, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    idle(2, "g8");

    send_frame("abort", 8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, (1 + 3) * 8 + 4);
    idle(20, "post_abort");
    send_frame("after_abort_7E", 8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
    idle(2, "g9");

    for (int k = 0; k < 24; k++) begin
      d    = DW'($urandom);
      p    = 8 << $urandom_range(0, 2);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      bp   = pen && ($urandom_range(0, 3) == 0);
      sb   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 2) == 0) begin
        gb = $urandom_range(0, 9 + int'(pen));
        go = $urandom_range(1, p - 1);
      end else begin
        gb = -1;
        go = 0;
      end
      send_frame($sformatf("rnd%0d", k), d, p, pen, ptyp, bp, sb, gb, go, -1);
      gap = $urandom_range(0, 3);
      if (gap > 0) idle(gap, $sformatf("rnd%0d_gap", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
